aes_round_sequencer: RTL and testbench

//  Sequences one AES-128 encryption through the registered addRoundKey stage. Owns the 128-bit state register and round counter.

---
 rtl/aes_round_sequencer_if.sv | 31 +++
 rtl/aes_round_sequencer.sv | 122 ++++++++++++
 tb/tb_aes_round_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_if.sv
// Bundles the cipher-side, key-schedule, round-function and addRoundKey
// signals of the AES round sequencer. The master modport is the sequencer.
interface aes_round_sequencer_if #(
    parameter int unsigned W = 128
);
    logic         start;
    logic [W-1:0] block_in;
    logic         busy;
    logic         done;
    logic [W-1:0] block_out;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [W-1:0] rk_data;
    logic [W-1:0] rnd_in;
    logic         rnd_last;
    logic [W-1:0] rnd_out;
    logic [W-1:0] ark_data;
    logic [W-1:0] ark_key;
    logic [W-1:0] ark_out;

    modport master (
        input  start, block_in, rk_valid, rk_data, rnd_out, ark_out,
        output busy, done, block_out, rk_req, rk_idx, rnd_in, rnd_last, ark_data, ark_key
    );

    modport slave (
        output start, block_in, rk_valid, rk_data, rnd_out, ark_out,
        input  busy, done, block_out, rk_req, rk_idx, rnd_in, rnd_last, ark_data, ark_key
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Steps one AES-128 block through round-key fetch and addRoundKey for rounds
// 0..NR, owning the state register, round counter and ARK operand registers.
module aes_round_sequencer #(
    parameter int unsigned NR      = 10,
    parameter int unsigned ARK_LAT = 1,
    parameter int unsigned W       = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_round_sequencer_if.master bus
);
    localparam int unsigned RW = 4;
    localparam int unsigned CW = (ARK_LAT > 0) ? $clog2(ARK_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ARK   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [W-1:0]  st_q, st_d;
    logic [W-1:0]  ark_data_q, ark_data_d;
    logic [W-1:0]  ark_key_q, ark_key_d;
    logic [W-1:0]  block_out_q, block_out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rk_req_q, rk_req_d;
    logic          rnd_last_q, rnd_last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_q     <= '0;
            wcnt_q      <= '0;
            st_q        <= '0;
            ark_data_q  <= '0;
            ark_key_q   <= '0;
            block_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rk_req_q    <= 1'b0;
            rnd_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            wcnt_q      <= wcnt_d;
            st_q        <= st_d;
            ark_data_q  <= ark_data_d;
            ark_key_q   <= ark_key_d;
            block_out_q <= block_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rk_req_q    <= rk_req_d;
            rnd_last_q  <= rnd_last_d;
        end
    end

    // Next state; status flags are registered from the next-state decode
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        wcnt_d      = wcnt_q;
        st_d        = st_q;
        ark_data_d  = ark_data_q;
        ark_key_d   = ark_key_q;
        block_out_d = block_out_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    st_d    = bus.block_in;
                    round_d = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (bus.rk_valid) begin
                    ark_key_d  = bus.rk_data;
                    ark_data_d = (round_q == '0) ? st_q : bus.rnd_out;
                    wcnt_d     = '0;
                    state_d    = S_ARK;
                end
            end
            S_ARK: begin
                if (wcnt_q == CW'(ARK_LAT)) begin
                    st_d = bus.ark_out;
                    if (round_q == RW'(NR)) begin
                        block_out_d = bus.ark_out;
                        state_d     = S_DONE;
                    end else begin
                        round_d = RW'(round_q + RW'(1));
                        state_d = S_FETCH;
                    end
                end else begin
                    wcnt_d = CW'(wcnt_q + CW'(1));
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d == S_FETCH) || (state_d == S_ARK);
        done_d     = (state_d == S_DONE);
        rk_req_d   = (state_d == S_FETCH);
        rnd_last_d = (round_d == RW'(NR));
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.block_out = block_out_q;
    assign bus.rk_req    = rk_req_q;
    assign bus.rk_idx    = round_q;
    assign bus.rnd_in    = st_q;
    assign bus.rnd_last  = rnd_last_q;
    assign bus.ark_data  = ark_data_q;
    assign bus.ark_key   = ark_key_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES round function, registered
// addRoundKey and a key-schedule model with a programmable rk_valid delay.
module tb_aes_round_sequencer;
    localparam int unsigned W  = 128;
    localparam int unsigned NR = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_round_sequencer_if #(.W(W)) ifc();
    aes_round_sequencer #(.NR(NR), .ARK_LAT(1), .W(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rkeys [11];
    logic         kv = 1'b0;
    logic         inj = 1'b0;
    int           kwait = 0;
    int           kdelay = 0;

    // ---------------- AES reference helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int k = 0; k < 16; k++) a[k] = sbox[s[127-8*k -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = a[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) a[4*c+r] = t[4*c+r];
            end else begin
                a[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                a[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                a[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                a[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end
        end
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = a[k];
        return o;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rkeys[0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, r == 10) ^ rkeys[r];
        return s;
    endfunction

    // ---------------- environment models ----------------
    assign ifc.rk_valid = kv | inj;

    always @(posedge clk) ifc.ark_out <= ifc.ark_data ^ ifc.ark_key;

    // Round function and key schedule respond shortly after each edge
    always @(posedge clk) begin
        #2;
        ifc.rnd_out = aes_round(ifc.rnd_in, ifc.rnd_last);
        ifc.rk_data = (ifc.rk_idx <= 4'd10) ? rkeys[ifc.rk_idx] : 128'h0;
        if (ifc.rk_req) begin
            kv = (kwait == kdelay);
            kwait++;
        end else begin
            kv = 1'b0;
            kwait = 0;
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           delay;
        int           lat;
        int           pa;
        int           pb;
        int           inj_cyc;
    } vec_t;

    // One full encryption with optional stray start pulses and an rk_valid injection
    task automatic run_enc(input vec_t v, input int id);
        int cyc;
        int acc;
        bit got;
        expand(v.key);
        kdelay = v.delay;
        acc = 0;
        got = 1'b0;
        cyc = 0;
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.block_in = v.pt;
        @(posedge clk);
        while (1) begin
            @(negedge clk);
            if (cyc == 0) begin
                check($sformatf("v%0d busy_after_start", id), ifc.busy, 1);
                check($sformatf("v%0d rnd_last_round0", id), ifc.rnd_last, 0);
            end
            if (v.inj_cyc >= 0 && cyc == v.inj_cyc + 1) begin
                check($sformatf("v%0d ark_key_held", id), ifc.ark_key, rkeys[0]);
                check($sformatf("v%0d ark_data_held", id), ifc.ark_data, v.pt);
            end
            if (ifc.rk_req) begin
                check($sformatf("v%0d rk_idx", id), ifc.rk_idx, acc);
                if (ifc.rk_valid) begin
                    check($sformatf("v%0d rnd_last_at_fetch%0d", id, acc), ifc.rnd_last, acc == NR);
                    acc++;
                end
            end
            if (ifc.done) begin
                got = 1'b1;
                break;
            end
            if (cyc >= v.lat + 40) break;
            ifc.start = (cyc == v.pa) || (cyc == v.pb);
            inj = (cyc == v.inj_cyc);
            @(posedge clk);
            cyc++;
        end
        ifc.start = 1'b0;
        inj = 1'b0;
        check($sformatf("v%0d done_seen", id), got, 1);
        check($sformatf("v%0d latency", id), cyc, v.lat);
        check($sformatf("v%0d ciphertext", id), ifc.block_out, v.ct);
        check($sformatf("v%0d busy_at_done", id), ifc.busy, 0);
        check($sformatf("v%0d keys_fetched", id), acc, NR + 1);
        check($sformatf("v%0d rnd_last_at_done", id), ifc.rnd_last, 1);
        step();
        check($sformatf("v%0d done_one_cycle", id), ifc.done, 0);
        check($sformatf("v%0d idle_not_busy", id), ifc.busy, 0);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         vecs [5];
        vec_t         rv;
        logic [7:0]   inv;
        logic [7:0]   b;
        logic [127:0] pt2;
        logic [127:0] ct2;
        int           cyc;
        int           ndone;
        bit           held;

        vecs[0] = '{C1_KEY, C1_PT, C1_CT, 0, 33, -1, -1, -1};
        vecs[1] = '{C1_KEY, C1_PT, C1_CT, 3, 66, -1, -1, -1};
        vecs[2] = '{B_KEY,  B_PT,  B_CT,  1, 44, -1, -1, -1};
        vecs[3] = '{C1_KEY, C1_PT, C1_CT, 0, 33,  5, 20, -1};
        vecs[4] = '{B_KEY,  B_PT,  B_CT,  0, 33, -1, -1,  1};

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        ifc.start = 1'b0;
        ifc.block_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", ifc.busy, 0);
        check("reset done", ifc.done, 0);
        check("reset rk_req", ifc.rk_req, 0);
        check("reset block_out", ifc.block_out, 0);
        check("reset rnd_in", ifc.rnd_in, 0);
        check("reset rk_idx", ifc.rk_idx, 0);
        check("reset rnd_last", ifc.rnd_last, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_enc(vecs[i], i);

        // rk_valid while idle must not move anything
        inj = 1'b1;
        step();
        inj = 1'b0;
        step();
        check("idle_inj busy", ifc.busy, 0);
        check("idle_inj rk_req", ifc.rk_req, 0);
        check("idle_inj ark_key", ifc.ark_key, rkeys[NR]);

        for (int i = 0; i < 6; i++) begin
            rv.key = {$urandom, $urandom, $urandom, $urandom};
            rv.pt  = {$urandom, $urandom, $urandom, $urandom};
            rv.delay = int'($urandom_range(0, 2));
            expand(rv.key);
            rv.ct = ref_enc(rv.pt);
            rv.lat = 33 + 11 * rv.delay;
            rv.pa = -1;
            rv.pb = -1;
            rv.inj_cyc = -1;
            run_enc(rv, 10 + i);
        end

        // Back-to-back: start held through DONE with a second plaintext
        expand(C1_KEY);
        kdelay = 0;
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        ct2 = ref_enc(pt2);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.block_in = C1_PT;
        @(posedge clk);
        @(negedge clk);
        ifc.block_in = pt2;
        cyc = 0;
        while (!ifc.done && cyc < 80) begin
            step();
            cyc++;
        end
        check("b2b first latency", cyc, 33);
        check("b2b first ct", ifc.block_out, C1_CT);
        step();
        cyc++;
        ifc.start = 1'b0;
        check("b2b no idle busy", ifc.busy, 1);
        check("b2b done dropped", ifc.done, 0);
        held = 1'b1;
        while (!ifc.done && cyc < 150) begin
            if (ifc.block_out !== C1_CT) held = 1'b0;
            step();
            cyc++;
        end
        check("b2b block_out held", held, 1);
        check("b2b second latency", cyc, 67);
        check("b2b second ct", ifc.block_out, ct2);

        // Reset during round 4 ARK aborts the block
        step();
        expand(C1_KEY);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.block_in = C1_PT;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (13) step();
        check("pre_rst busy", ifc.busy, 1);
        check("pre_rst round", ifc.rk_idx, 4);
        rst = 1'b1;
        step();
        check("rst busy", ifc.busy, 0);
        check("rst done", ifc.done, 0);
        check("rst rk_req", ifc.rk_req, 0);
        check("rst block_out", ifc.block_out, 0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ifc.done) ndone++;
        end
        check("rst no done", ndone, 0);
        run_enc(vecs[0], 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
